// File: rtl/instr_memory_pkg.sv
// -----------------------------------------------------------------------------
// instr_memory_pkg
//   Shared constants for the instruction memory: the RISC-V NOP used as the
//   fill word, the default geometry, and the built-in default program image.
// -----------------------------------------------------------------------------
package instr_memory_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam int DEFAULT_ADDR_W = 11;
  localparam int DEFAULT_DEPTH  = 2048;

  // Built-in image used when no INIT_FILE is given; every other word is fill.
  localparam int          DEFAULT_IMAGE_LEN = 3;
  localparam logic [31:0] DEFAULT_IMAGE [DEFAULT_IMAGE_LEN] = '{
    32'h0000_0013,
    32'h0000_0023,
    32'h0000_0012
  };

endpackage : instr_memory_pkg

// File: rtl/instr_memory.sv
// -----------------------------------------------------------------------------
// instr_memory
//   Word-addressed instruction memory for the CPU fetch stage. Reads are purely
//   combinational (addr -> instr in the same cycle, no clock or reset
//   involvement). Contents are preloaded at elaboration from the built-in
//   default image overlaid on FILL_WORD.
//
//   Optional feature, macro INSTR_MEM_LOAD_EN:
//     defined   - sequential load port appends load_data at load_count on each
//                 accepted clock edge; the pointer saturates at DEPTH.
//     undefined - pure ROM; load_valid/load_data ignored, load_ready and
//                 load_count tied to 0.
//
// Ports:
//   clk         clock, used only by the load port
//   rst_n       asynchronous active-low reset (load pointer only)
//   addr        word address (not a byte address)
//   instr       instruction word at addr, FILL_WORD when addr >= DEPTH
//   load_valid  load-port write strobe
//   load_data   word to append
//   load_ready  high while the load pointer is below DEPTH
//   load_count  words written since reset
// -----------------------------------------------------------------------------
module instr_memory
  import instr_memory_pkg::*;
#(
  parameter int          ADDR_W    = DEFAULT_ADDR_W,
  parameter int          DEPTH     = DEFAULT_DEPTH,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] FILL_WORD = INSTR_NOP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       instr,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  output logic [ADDR_W:0]   load_count
);

  localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef logic [31:0] image_t [DEPTH];

  // Whole array starts as FILL_WORD; the built-in program is laid over it
  // when no image name is given.
  function automatic image_t build_image();
    image_t img;
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = FILL_WORD;
    end
    if (INIT_FILE == "") begin
      for (int i = 0; i < DEFAULT_IMAGE_LEN && i < DEPTH; i++) begin
        img[i] = DEFAULT_IMAGE[i];
      end
    end
    return img;
  endfunction

  image_t mem = build_image();

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic in_range;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    in_range = {1'b0, addr} < DEPTH_CNT;
    instr    = FILL_WORD;
    if (in_range) begin
      instr = mem[addr[IDX_W-1:0]];
    end
  end

`ifdef INSTR_MEM_LOAD_EN
  // ---------------------------------------------------------------------------
  // Sequential load port
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;

  assign load_ready = count_q < DEPTH_CNT;
  assign load_count = count_q;

  // Writes are suppressed while reset is held so a strobe during reset cannot
  // land a word at the freshly cleared pointer.
  always_comb begin
    wr_en   = load_valid && load_ready && rst_n;
    count_d = count_q;
    if (wr_en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge values of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // NOTE: the array itself has no reset; reset only restarts the load pointer
  // and the loaded program survives it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count_q[IDX_W-1:0]] <= load_data;
    end
  end
`else
  // Pure ROM: the load port exists but does nothing.
  assign load_ready = 1'b0;
  assign load_count = '0;

  logic unused_load_port;
  assign unused_load_port = ^{clk, rst_n, load_valid, load_data};
`endif

endmodule : instr_memory

// File: tb/tb_instr_memory.sv
// -----------------------------------------------------------------------------
// tb_instr_memory
//   Directed bench for instr_memory. Three instances: default geometry, a
//   16-word memory for out-of-range reads, and a 4-word memory for pointer
//   saturation. Branches on INSTR_MEM_LOAD_EN to match the build.
// -----------------------------------------------------------------------------
module tb_instr_memory;

  logic        clk = 1'b0;
  logic        rst_n;

  // default instance (ADDR_W 11, DEPTH 2048)
  logic [10:0] addr;
  logic [31:0] instr;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic [11:0] load_count;

  // small instance (DEPTH 16)
  logic [10:0] s_addr;
  logic [31:0] s_instr;
  logic        s_ready;
  logic [11:0] s_count;

  // tiny instance (ADDR_W 2, DEPTH 4)
  logic [1:0]  t_addr;
  logic [31:0] t_instr;
  logic        t_valid;
  logic [31:0] t_data;
  logic        t_ready;
  logic [2:0]  t_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_memory u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .instr      (instr),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_count (load_count)
  );

  instr_memory #(.ADDR_W(11), .DEPTH(16)) u_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (s_addr),
    .instr      (s_instr),
    .load_valid (1'b0),
    .load_data  (32'h0),
    .load_ready (s_ready),
    .load_count (s_count)
  );

  instr_memory #(.ADDR_W(2), .DEPTH(4)) u_tiny (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (t_addr),
    .instr      (t_instr),
    .load_valid (t_valid),
    .load_data  (t_data),
    .load_ready (t_ready),
    .load_count (t_count)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One accepted word on the default instance: strobe across one rising edge.
  task automatic load_main(input logic [31:0] d);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic load_tiny(input logic [31:0] d);
    @(negedge clk);
    t_valid = 1'b1;
    t_data  = d;
    @(negedge clk);
    t_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    addr       = '0;
    s_addr     = '0;
    t_addr     = '0;
    load_valid = 1'b0;
    load_data  = '0;
    t_valid    = 1'b0;
    t_data     = '0;

    // ---- reset state and default image ----
    #10;
    check("rst_count", 32'(load_count), 32'h0);
`ifdef INSTR_MEM_LOAD_EN
    check("rst_ready", 32'(load_ready), 32'h1);
`else
    check("rst_ready", 32'(load_ready), 32'h0);
`endif
    check("img_w0", instr, 32'h0000_0013);
    addr = 11'd1;    #10; check("img_w1", instr, 32'h0000_0023);
    addr = 11'd2;    #10; check("img_w2", instr, 32'h0000_0012);
    addr = 11'd3;    #10; check("img_w3_fill", instr, 32'h0000_0013);
    addr = 11'd2047; #10; check("img_w2047_fill", instr, 32'h0000_0013);
    s_addr = 11'd100; #10; check("small_oor_100", s_instr, 32'h0000_0013);
    s_addr = 11'd2;   #10; check("small_w2", s_instr, 32'h0000_0012);
    s_addr = 11'd16;  #10; check("small_oor_16", s_instr, 32'h0000_0013);

    @(negedge clk);
    rst_n = 1'b1;

`ifdef INSTR_MEM_LOAD_EN
    // ---- sequential load ----
    load_main(32'hDEAD_BEEF);
    load_main(32'h0050_0093);
    check("load_count2", 32'(load_count), 32'd2);
    addr = 11'd0; #10; check("load_w0", instr, 32'hDEAD_BEEF);
    addr = 11'd1; #10; check("load_w1", instr, 32'h0050_0093);
    addr = 11'd2; #10; check("load_w2_kept", instr, 32'h0000_0012);

    // old word until the edge, new word right after it
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 32'hCAFE_F00D;
    #1; check("wr_before_edge", instr, 32'h0000_0012);
    @(posedge clk);
    #1; check("wr_after_edge", instr, 32'hCAFE_F00D);
    check("load_count3", 32'(load_count), 32'd3);
    @(negedge clk);
    load_valid = 1'b0;

    // ---- saturation on the 4-word instance ----
    for (int i = 0; i < 5; i++) begin
      load_tiny(32'hA000_0000 + 32'(i));
    end
    check("sat_count", 32'(t_count), 32'd4);
    check("sat_ready", 32'(t_ready), 32'h0);
    t_addr = 2'd0; #10; check("sat_w0", t_instr, 32'hA000_0000);
    t_addr = 2'd3; #10; check("sat_w3", t_instr, 32'hA000_0003);

    // ---- asynchronous reset mid-cycle, no clock edge involved ----
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(load_count), 32'h0);
    check("arst_ready", 32'(load_ready), 32'h1);
    check("arst_t_count", 32'(t_count), 32'h0);
    check("arst_t_ready", 32'(t_ready), 32'h1);
    addr = 11'd1; #1; check("arst_w1_kept", instr, 32'h0050_0093);

    // pointer restarts at 0, other loaded words stay
    @(negedge clk);
    rst_n = 1'b1;
    load_tiny(32'h1234_5678);
    check("reload_t_count", 32'(t_count), 32'd1);
    t_addr = 2'd0; #10; check("reload_t_w0", t_instr, 32'h1234_5678);
    t_addr = 2'd1; #10; check("reload_t_w1", t_instr, 32'hA000_0001);
`else
    // ---- ROM: load strobes ignored ----
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 32'hFFFF_FFFF;
    t_valid    = 1'b1;
    t_data     = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    load_valid = 1'b0;
    t_valid    = 1'b0;
    addr = 11'd0; #10; check("rom_w0", instr, 32'h0000_0013);
    addr = 11'd1; #10; check("rom_w1", instr, 32'h0000_0023);
    addr = 11'd2; #10; check("rom_w2", instr, 32'h0000_0012);
    check("rom_count", 32'(load_count), 32'h0);
    check("rom_ready", 32'(load_ready), 32'h0);
    check("rom_t_count", 32'(t_count), 32'h0);
    t_addr = 2'd0; #10; check("rom_t_w0", t_instr, 32'h0000_0013);

    // ---- asynchronous reset mid-cycle ----
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(load_count), 32'h0);
    addr = 11'd1; #1; check("arst_w1_kept", instr, 32'h0000_0023);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_instr_memory
